csa_resolver: RTL and testbench

- Carry-propagate back end for the carry-save adder stage: takes one redundant (sum, carry) vector pair and resolves it to a conventional unsigned binary value.
- The carry vector is weighted one bit left of the sum vector: carry[i] has weight 2^(i+1).
- Resolution is multi-cycle: a CHUNK-bit slice adder iterates LSB-first with a registered carry. This keeps the carry chain short at the output of the convolution datapath.
- Valid/ready handshake on both sides; one operation in flight.

---
 rtl/csa_resolver.sv | 132 +++++++++++++
 tb/tb_csa_resolver.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_resolver.sv
// Resolves a carry-save (sum, carry) pair into a plain binary value using a
// narrow slice adder that walks the operand LSB-first, one CHUNK per cycle.
module csa_resolver #(
    parameter int W     = 13,
    parameter int CHUNK = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_sum,
    input  logic [W-1:0]   in_carry,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W+1:0]   out_value,
    output logic           busy
);

    localparam int WO     = W + 2;
    localparam int NCHUNK = (WO + CHUNK - 1) / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WO-1:0]   a_reg;
    logic [WO-1:0]   b_reg;
    logic [WO-1:0]   result;
    logic [WO-1:0]   result_next;
    logic            carry;
    logic [KW-1:0]   k;
    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK:0]  slice_sum;
    logic            last_slice;

    assign last_slice = (int'(k) == NCHUNK - 1);

    // Bits of the last slice beyond the operand width read as zero.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < WO; i++) begin
            if (i / CHUNK == int'(k)) begin
                a_slice[i % CHUNK] = a_reg[i];
                b_slice[i % CHUNK] = b_reg[i];
            end
        end
    end

    assign slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry};

    always_comb begin
        result_next = result;
        for (int i = 0; i < WO; i++) begin
            if (i / CHUNK == int'(k)) begin
                result_next[i] = slice_sum[i % CHUNK];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_slice) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The carry vector carries weight 2^(i+1), hence the one-bit left shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg  <= '0;
            b_reg  <= '0;
            result <= '0;
            carry  <= 1'b0;
            k      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= {2'b00, in_sum};
                        b_reg <= {1'b0, in_carry, 1'b0};
                        carry <= 1'b0;
                        k     <= '0;
                    end
                end
                RUN: begin
                    result <= result_next;
                    carry  <= slice_sum[CHUNK];
                    k      <= last_slice ? '0 : k + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_value = result;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_csa_resolver.sv
// Bench for csa_resolver: directed cases on CHUNK=4 plus randomized traffic on
// CHUNK=1, 4 and 15 instances, all checked against a queue-based model.
module tb_csa_resolver;

    localparam int W  = 13;
    localparam int WO = W + 2;
    localparam int NI = 3;
    localparam int CHS [NI] = '{1, 4, 15};

    typedef struct {
        int inst;
        int val;
        int acc;
    } entry_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NI-1:0]     in_valid = '0;
    logic [NI-1:0]     in_ready;
    logic [NI-1:0]     out_valid;
    logic [NI-1:0]     out_ready = '1;
    logic [NI-1:0]     busy;
    logic [W-1:0]      in_sum   [NI];
    logic [W-1:0]      in_carry [NI];
    logic [WO-1:0]     out_value [NI];
    logic [NI-1:0]     final_carry;
    logic [NI-1:0]     prev_valid = '0;
    logic [NI-1:0]     prev_taken = '0;

    int     checks = 0;
    int     errors = 0;
    int     cycle = 0;
    bit     rand_done = 0;
    entry_t model[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    csa_resolver #(.W(W), .CHUNK(CHS[0])) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_sum(in_sum[0]), .in_carry(in_carry[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_value(out_value[0]), .busy(busy[0]));
    csa_resolver #(.W(W), .CHUNK(CHS[1])) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_sum(in_sum[1]), .in_carry(in_carry[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_value(out_value[1]), .busy(busy[1]));
    csa_resolver #(.W(W), .CHUNK(CHS[2])) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_sum(in_sum[2]), .in_carry(in_carry[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_value(out_value[2]), .busy(busy[2]));

    assign final_carry = {u2.carry, u1.carry, u0.carry};

    function automatic int nchunk_of(int c);
        return (WO + c - 1) / c;
    endfunction

    function automatic int find_first(int i);
        foreach (model[j]) begin
            if (model[j].inst == i) return j;
        end
        return -1;
    endfunction

    task automatic check_output(string name, int actual, int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at cycle %0d",
                     name, actual, expected, cycle);
        end
    endtask

    // Model: every accepted pair must come back once, in order, as sum+2*carry.
    always @(negedge clk) begin
        if (!rst_n) begin
            model.delete();
            prev_valid = '0;
            prev_taken = '0;
            for (int i = 0; i < NI; i++) begin
                check_output("reset_out_valid", int'(out_valid[i]), 0);
                check_output("reset_busy", int'(busy[i]), 0);
                check_output("reset_out_value", int'(out_value[i]), 0);
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                int idx;
                if (in_valid[i] && in_ready[i]) begin
                    model.push_back('{i, int'(in_sum[i]) + 2 * int'(in_carry[i]), cycle + 1});
                end
                check_output("ready_vs_busy", int'(in_ready[i]), int'(!busy[i]));
                if (prev_valid[i] && !prev_taken[i]) begin
                    check_output("valid_held", int'(out_valid[i]), 1);
                end
                if (out_valid[i]) begin
                    idx = find_first(i);
                    if (idx < 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL spurious_output inst=%0d actual=0x%0h expected=none",
                                 i, out_value[i]);
                    end else begin
                        check_output("value", int'(out_value[i]), model[idx].val);
                        if (!prev_valid[i]) begin
                            check_output("latency", cycle - model[idx].acc, nchunk_of(CHS[i]));
                            check_output("top_carry", int'(final_carry[i]), 0);
                        end
                        if (out_ready[i]) model.delete(idx);
                    end
                end
                prev_valid[i] = out_valid[i];
                prev_taken[i] = out_valid[i] && out_ready[i];
            end
        end
    end

    task automatic apply_stimulus(int i, logic [W-1:0] s, logic [W-1:0] c, output int acc);
        bit got;
        got = 0;
        acc = 0;
        @(posedge clk);
        #1;
        in_sum[i]   = s;
        in_carry[i] = c;
        in_valid[i] = 1'b1;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (in_ready[i]) begin
                got = 1;
                acc = cycle + 1;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout inst=%0d actual=no_accept expected=accept", i);
        end
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
        in_sum[i]   = W'($urandom);
        in_carry[i] = W'($urandom);
    endtask

    task automatic wait_result(int i, int acc, output int val, output int lat);
        bit got;
        got = 0;
        val = -1;
        lat = -1;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (out_valid[i]) begin
                got = 1;
                val = int'(out_value[i]);
                lat = cycle - acc;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL result_timeout inst=%0d actual=no_valid expected=valid", i);
        end
    endtask

    task automatic run_random(int i, int count);
        int acc;
        for (int n = 0; n < count; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            apply_stimulus(i, W'($urandom), W'($urandom), acc);
        end
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int val;
        int lat;
        for (int i = 0; i < NI; i++) begin
            in_sum[i]   = '0;
            in_carry[i] = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_output("post_reset_out_valid", int'(out_valid[1]), 0);
        check_output("post_reset_out_value", int'(out_value[1]), 0);
        check_output("post_reset_busy", int'(busy[1]), 0);
        check_output("post_reset_in_ready", int'(in_ready[1]), 1);

        apply_stimulus(1, 13'h0AAA, 13'h0555, acc);
        wait_result(1, acc, val, lat);
        check_output("alt_pattern_value", val, 'h1554);
        check_output("alt_pattern_latency", lat, 4);
        @(negedge clk);
        check_output("single_valid_cycle", int'(out_valid[1]), 0);
        check_output("ready_after_output", int'(in_ready[1]), 1);

        apply_stimulus(1, 13'h1FFF, 13'h1FFF, acc);
        wait_result(1, acc, val, lat);
        check_output("max_value", val, 'h5FFD);
        check_output("max_top_carry", int'(final_carry[1]), 0);
        @(negedge clk);

        out_ready[1] = 1'b0;
        apply_stimulus(1, 13'h0001, 13'h0FFF, acc);
        wait_result(1, acc, val, lat);
        check_output("stall_value", val, 'h1FFF);
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            in_valid[1] = 1'b1;
            in_sum[1]   = W'($urandom);
            in_carry[1] = W'($urandom);
            @(negedge clk);
            check_output("stall_valid", int'(out_valid[1]), 1);
            check_output("stall_held_value", int'(out_value[1]), 'h1FFF);
            check_output("stall_in_ready", int'(in_ready[1]), 0);
        end
        @(posedge clk);
        #1;
        in_valid[1]  = 1'b0;
        out_ready[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_output("stall_release_ready", int'(in_ready[1]), 1);
        check_output("stall_release_valid", int'(out_valid[1]), 0);

        apply_stimulus(1, 13'h1234, 13'h0000, acc);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("abort_out_valid", int'(out_valid[1]), 0);
        check_output("abort_busy", int'(busy[1]), 0);
        check_output("abort_out_value", int'(out_value[1]), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check_output("abort_no_output", int'(out_valid[1]), 0);
        end
        apply_stimulus(1, 13'h0003, 13'h0002, acc);
        wait_result(1, acc, val, lat);
        check_output("after_abort_value", val, 7);
        check_output("after_abort_latency", lat, 4);
        @(negedge clk);

        fork
            begin
                fork
                    run_random(0, 2000);
                    run_random(1, 2000);
                    run_random(2, 2000);
                join
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    for (int i = 0; i < NI; i++) out_ready[i] = ($urandom_range(0, 3) != 0);
                end
            end
        join

        out_ready = '1;
        for (int n = 0; n < 100 && model.size() > 0; n++) @(negedge clk);
        repeat (2) @(negedge clk);
        check_output("drain_empty", model.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
